// File: rtl/image_mem_sequencer.sv
// image_mem_sequencer: loads a frame into RAM, runs the core on it, then streams the result region out.
// Define FRAME_LOOP_EN to re-arm for the next frame after DONE instead of stopping there.
module image_mem_sequencer #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 10,
    parameter int IN_COUNT  = 65536,
    parameter int OUT_BASE  = 65536,
    parameter int OUT_COUNT = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              core_row,
    input  logic              core_flag,
    output logic              core_start,
    output logic              core_reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_row,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done
);
    localparam int LW = $clog2(IN_COUNT + 1);
    localparam int OW = $clog2(OUT_COUNT + 1);

    typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    boot, boot_nxt;
    logic [LW-1:0] load_cnt;
    logic [OW-1:0] rd_cnt, wr_cnt;
    logic          rd_pending, in_fire, out_fire, rd_issue;

    // boot counts down 2 -> 1 -> 0: held in reset, then one cycle of core_reset before loading
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= LOAD;
            boot  <= 2'd2;
        end else begin
            state <= state_nxt;
            boot  <= boot_nxt;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            load_cnt   <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (state == DONE) begin
            load_cnt   <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_pending <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            if (in_fire) load_cnt <= load_cnt + LW'(1);
            if (rd_issue) rd_cnt <= rd_cnt + OW'(1);
            if (out_fire) wr_cnt <= wr_cnt + OW'(1);
            rd_pending <= rd_issue;
            if (rd_pending) begin
                out_data  <= mem_rdata;
                out_valid <= 1'b1;
            end else if (out_fire) out_valid <= 1'b0;
        end

    always_comb begin
        state_nxt  = state;
        boot_nxt   = boot - {1'b0, boot != 2'd0};
        in_ready   = state == LOAD && boot == 2'd0;
        in_fire    = in_ready && in_valid;
        out_fire   = state == DRAIN && out_valid && out_ready;
        rd_issue   = state == DRAIN && !rd_pending && (!out_valid || out_ready) && rd_cnt < OW'(OUT_COUNT);
        core_start = state == RUN;
        core_reset = boot != 2'd0;
        busy       = state != DONE && boot != 2'd2;
        done       = state == DONE;
        mem_row    = core_start ? core_row : in_fire;
        mem_wdata  = core_start ? core_wdata : in_fire ? in_data : '0;
        mem_addr   = core_start ? core_addr :
                     in_fire    ? ADDR_W'(load_cnt) :
                     rd_issue   ? ADDR_W'(OUT_BASE) + ADDR_W'(rd_cnt) : '0;
        unique case (state)
            LOAD:  if (in_fire && load_cnt == LW'(IN_COUNT - 1)) state_nxt = RUN;
            RUN:   if (core_flag) state_nxt = DRAIN;
            DRAIN: if (out_fire && wr_cnt == OW'(OUT_COUNT - 1)) state_nxt = DONE;
            DONE: begin
`ifdef FRAME_LOOP_EN
                state_nxt = LOAD;
                boot_nxt  = 2'd1;
`else
                state_nxt = DONE;
`endif
            end
        endcase
    end
endmodule

// File: tb/tb_image_mem_sequencer.sv
// tb_image_mem_sequencer: randomized frames against a memory-level model; a monitor scores the output stream.
module tb_image_mem_sequencer;
    localparam int AW = 20, DW = 10, IC = 4, OB = 16, OC = 2;

    logic          clk = 1'b0, reset = 1'b1;
    logic [DW-1:0] in_data = '0, out_data, core_wdata = '0, mem_wdata, mem_rdata;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [AW-1:0] core_addr = '0, mem_addr;
    logic          core_row = 1'b0, core_flag = 1'b0, core_start, core_reset, mem_row, busy, done;

    image_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .IN_COUNT(IC), .OUT_BASE(OB), .OUT_COUNT(OC)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_row(core_row), .core_flag(core_flag),
        .core_start(core_start), .core_reset(core_reset),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_row(mem_row), .mem_rdata(mem_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // registered-read RAM, small enough to cover the addresses used here
    logic [DW-1:0] ram [0:31];
    always @(posedge clk) begin
        if (mem_row) ram[mem_addr[4:0]] <= mem_wdata;
        mem_rdata <= ram[mem_addr[4:0]];
    end

    int            checks = 0, errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] mdl [0:31];
    logic [DW-1:0] ld [IC];
    logic [DW-1:0] cw [OC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;
    always @(negedge clk) begin
        if (reset) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
            end
            check("mem_row_mux", mem_row, core_start ? core_row : (in_valid && in_ready));
            if (core_start) begin
                check("run_addr_mux", mem_addr, core_addr);
                check("run_wdata_mux", mem_wdata, core_wdata);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected actual=%0h required=none", out_data);
                end else check("out_data", out_data, exp_q.pop_front());
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_data;
        end
    end

    task automatic reset_seq();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; core_flag = 1'b0; core_row = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_reset", core_reset, 1);
        check("rst_mem", {mem_row, mem_addr, mem_wdata}, 0);
        check("rst_busy_done", {busy, done}, 0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("boot1_core_reset", core_reset, 1);
        check("boot1_busy", busy, 1);
        check("boot1_in_ready", in_ready, 0);
        @(negedge clk);
        check("boot2_core_reset", core_reset, 0);
        check("boot2_in_ready", in_ready, 1);
        check("boot2_busy_done", {busy, done}, 2'b10);
    endtask

    task automatic load_frame(input bit gaps);
        int i = 0;
        for (int t = 0; t < 100 && i < IC; t++) begin
            @(posedge clk); #1;
            in_valid = !gaps || (t % 2 == 0);
            in_data  = ld[i];
            if (in_valid && in_ready) begin
                mdl[i] = ld[i];
                i++;
            end
        end
        @(posedge clk); #1;
        check("load_in_ready_off", in_ready, 0);
        check("load_core_start", core_start, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < IC; k++) check("ram_load", ram[k], ld[k]);
    endtask

    task automatic core_run();
        for (int k = 0; k < OC; k++) begin
            core_addr  = AW'(OB + k);
            core_wdata = cw[k];
            core_row   = 1'b1;
            mdl[OB + k] = cw[k];
            @(posedge clk); #1;
        end
        core_row  = 1'b0;
        core_addr = AW'($urandom_range(0, 31));
        core_flag = 1'b1;
        for (int k = 0; k < OC; k++) exp_q.push_back(mdl[OB + k]);
        check("flag_core_start", core_start, 1);
        @(posedge clk); #1;
        check("drain_core_start", core_start, 0);
        check("drain_busy", busy, 1);
        core_flag = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        if (rnd) out_ready = 1'($urandom_range(0, 1));
        else begin
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
        end
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_strobes", {core_start, mem_row, in_ready, out_valid}, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset_seq();
        ld[0] = 10'h001; ld[1] = 10'h002; ld[2] = 10'h003; ld[3] = 10'h3FF;
        cw[0] = 10'h155; cw[1] = 10'h2AA;
        load_frame(1'b0);
        core_run();
        drain(1'b0);
        for (int k = 0; k < IC; k++) ld[k] = DW'($urandom);
        for (int k = 0; k < OC; k++) cw[k] = DW'($urandom);
`ifdef FRAME_LOOP_EN
        @(posedge clk); #1;
        check("loop_done_pulse", done, 0);
        check("loop_core_reset", core_reset, 1);
        check("loop_in_ready_off", in_ready, 0);
        @(posedge clk); #1;
        check("loop_core_reset_off", core_reset, 0);
        check("loop_in_ready", in_ready, 1);
`else
        repeat (3) @(posedge clk);
        #1;
        check("done_held", {done, busy, in_ready}, 3'b100);
        reset_seq();
`endif
        load_frame(1'b1);
        core_run();
        drain(1'b1);
        reset_seq();
        for (int k = 0; k < IC; k++) ld[k] = DW'($urandom);
        load_frame(1'b0);
        core_addr = AW'(OB); core_wdata = DW'($urandom); core_row = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_core_start", core_start, 0);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_mem_row", mem_row, 0);
        check("midrst_busy", busy, 0);
        core_row = 1'b0;
        reset_seq();
        for (int k = 0; k < IC; k++) ld[k] = DW'($urandom);
        load_frame(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
